// File: rtl/lif_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron array.
// Holds the sweep FSM encoding and a width-parametrised saturating add.
// Optional refractory behaviour is selected with the LIF_REFRACT_EN macro.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Working width for the saturation helper; wide enough for any sane V_WIDTH.
  localparam int SAT_W = 64;

  // Add two signed values and clamp the result to the signed range of w bits.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/lif_neuron_update.sv
// Combinational single-neuron LIF step: leak, integrate, saturate, threshold.
// Shared by every neuron of the array; the sweep feeds it one neuron per cycle.
// Refractory hold is compiled in only when LIF_REFRACT_EN is defined.
module lif_neuron_update
  import lif_pkg::*;
#(
  parameter int V_WIDTH    = 16,
  parameter int I_WIDTH    = 8,
  parameter int LEAK_SHIFT = 4,
  parameter int THRESH     = 1000,
  parameter int V_RESET    = 0,
  parameter int REFRACT    = 3,
  parameter int C_WIDTH    = 2
) (
  input  logic signed [V_WIDTH-1:0] v,
  input  logic signed [I_WIDTH-1:0] i,
  input  logic        [C_WIDTH-1:0] count,
  output logic signed [V_WIDTH-1:0] v_next,
  output logic                      spike,
  output logic        [C_WIDTH-1:0] count_next
);

  // Two guard bits keep v - leak + i exact before clamping.
  localparam int SW = V_WIDTH + 2;
  localparam logic signed [V_WIDTH-1:0] THR  = V_WIDTH'(THRESH);
  localparam logic signed [V_WIDTH-1:0] VRST = V_WIDTH'(V_RESET);

  logic signed [V_WIDTH-1:0] leak;
  logic signed [SW-1:0]      v_ext;
  logic signed [SW-1:0]      leak_ext;
  logic signed [SW-1:0]      i_ext;
  logic signed [SW-1:0]      s;
  logic signed [SAT_W-1:0]   s_wide;
  logic signed [SAT_W-1:0]   s_sat;
  logic signed [V_WIDTH-1:0] v_sat;
  logic                      fire;

  assign leak     = v >>> LEAK_SHIFT;
  assign v_ext    = {{2{v[V_WIDTH-1]}}, v};
  assign leak_ext = {{2{leak[V_WIDTH-1]}}, leak};
  assign i_ext    = {{(SW-I_WIDTH){i[I_WIDTH-1]}}, i};
  assign s        = v_ext - leak_ext + i_ext;
  assign s_wide   = {{(SAT_W-SW){s[SW-1]}}, s};
  assign s_sat    = sat_add(s_wide, 64'sd0, V_WIDTH);
  assign v_sat    = s_sat[V_WIDTH-1:0];
  assign fire     = (v_sat >= THR);

`ifdef LIF_REFRACT_EN
  // Integrate-and-fire, but a nonzero refractory count pins the neuron at reset.
  always_comb begin
    v_next     = fire ? VRST : v_sat;
    spike      = fire;
    count_next = fire ? C_WIDTH'(REFRACT) : '0;
    if (count != '0) begin
      v_next     = VRST;
      spike      = 1'b0;
      count_next = count - C_WIDTH'(1);
    end
  end
`else
  // Without refractory support the count input is ignored and stays zero.
  logic count_unused;
  localparam int REFRACT_UNUSED = REFRACT;
  assign count_unused = ^count;

  // Plain integrate-and-fire: a neuron may fire on consecutive sweeps.
  always_comb begin
    v_next     = fire ? VRST : v_sat;
    spike      = fire;
    count_next = '0;
  end
`endif

endmodule

// File: rtl/lif_array.sv
// Array of N leaky integrate-and-fire neurons sharing one update datapath.
// A tick captures all input currents, sweeps one neuron per cycle, then publishes spikes.
// Ticks arriving mid-sweep are dropped and flagged on sticky overrun; LIF_REFRACT_EN adds refractory counters.
module lif_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS  = 4,
  parameter int V_WIDTH    = 16,
  parameter int I_WIDTH    = 8,
  parameter int LEAK_SHIFT = 4,
  parameter int THRESH     = 1000,
  parameter int V_RESET    = 0,
  parameter int REFRACT    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic [N_NEURONS*I_WIDTH-1:0]   i_in,
  input  logic                           clr_overrun,
  input  logic [$clog2(N_NEURONS)-1:0]   v_mon_sel,
  output logic                           busy,
  output logic                           spike_valid,
  output logic [N_NEURONS-1:0]           spikes,
  output logic                           overrun,
  output logic signed [V_WIDTH-1:0]      v_mon
);

  localparam int IDX_W   = $clog2(N_NEURONS);
  localparam int C_WIDTH = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic signed [V_WIDTH-1:0] VRST = V_WIDTH'(V_RESET);
  localparam logic [IDX_W-1:0]          LAST = IDX_W'(N_NEURONS - 1);

  state_t                     state;
  logic [IDX_W-1:0]           idx;
  logic [N_NEURONS*I_WIDTH-1:0] i_shadow;
  logic signed [V_WIDTH-1:0]  v_mem   [N_NEURONS];
  logic [C_WIDTH-1:0]         cnt_mem [N_NEURONS];
  logic [N_NEURONS-1:0]       scratch;
  logic [N_NEURONS-1:0]       scratch_next;
  logic signed [I_WIDTH-1:0]  cur_i;
  logic signed [V_WIDTH-1:0]  upd_v;
  logic                       upd_spike;
  logic [C_WIDTH-1:0]         upd_cnt;

  assign cur_i = i_shadow[idx*I_WIDTH +: I_WIDTH];

  lif_neuron_update #(
    .V_WIDTH   (V_WIDTH),
    .I_WIDTH   (I_WIDTH),
    .LEAK_SHIFT(LEAK_SHIFT),
    .THRESH    (THRESH),
    .V_RESET   (V_RESET),
    .REFRACT   (REFRACT),
    .C_WIDTH   (C_WIDTH)
  ) u_update (
    .v         (v_mem[idx]),
    .i         (cur_i),
    .count     (cnt_mem[idx]),
    .v_next    (upd_v),
    .spike     (upd_spike),
    .count_next(upd_cnt)
  );

  // Merge the current neuron's spike so the last neuron lands in the published vector.
  always_comb begin
    scratch_next      = scratch;
    scratch_next[idx] = upd_spike;
  end

  // Sweep sequencer: capture on tick, update one neuron per cycle, publish in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      i_shadow    <= '0;
      scratch     <= '0;
      spikes      <= '0;
      spike_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_mem[k]   <= VRST;
        cnt_mem[k] <= '0;
      end
    end else begin
      spike_valid <= 1'b0;
      // A dropped tick beats a simultaneous clear.
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            i_shadow <= i_in;
            idx      <= '0;
            scratch  <= '0;
            busy     <= 1'b1;
            state    <= SWEEP;
          end
        end
        SWEEP: begin
          v_mem[idx]   <= upd_v;
          cnt_mem[idx] <= upd_cnt;
          scratch      <= scratch_next;
          if (idx == LAST) begin
            spikes      <= scratch_next;
            spike_valid <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Registered monitor tap; sees a neuron's new value one cycle after its write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_mon <= VRST;
    end else begin
      v_mon <= v_mem[v_mon_sel];
    end
  end

endmodule

// File: tb/tb_lif_array.sv
// Directed bench for lif_array: default instance plus a saturation-corner instance.
// Expected values are hand-computed constants; each comparison is an immediate assertion.
// Refractory expectations follow LIF_REFRACT_EN when the bench is built with it.
module tb_lif_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        rst, tick, clr;
  logic [31:0] i_in;
  logic [1:0]  sel;
  logic        busy, spike_valid, overrun;
  logic [3:0]  spikes;
  logic signed [15:0] v_mon;

  // Saturation instance
  logic        rst2, tick2, clr2;
  logic [31:0] i_in2;
  logic [1:0]  sel2;
  logic        busy2, spike_valid2, overrun2;
  logic [3:0]  spikes2;
  logic signed [15:0] v_mon2;

  lif_array dut (
    .clk(clk), .rst(rst), .tick(tick), .i_in(i_in), .clr_overrun(clr),
    .v_mon_sel(sel), .busy(busy), .spike_valid(spike_valid), .spikes(spikes),
    .overrun(overrun), .v_mon(v_mon)
  );

  lif_array #(.LEAK_SHIFT(15), .THRESH(32767)) dut_sat (
    .clk(clk), .rst(rst2), .tick(tick2), .i_in(i_in2), .clr_overrun(clr2),
    .v_mon_sel(sel2), .busy(busy2), .spike_valid(spike_valid2), .spikes(spikes2),
    .overrun(overrun2), .v_mon(v_mon2)
  );

  int vecs = 0;
  int errs = 0;

  logic [5:0] busy_pat, sv_pat;
  logic [3:0] sp_cap;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int c0, input int c1, input int c2, input int c3);
    return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  // One sweep on the default instance, observed over cycles t+1..t+6.
  task automatic sweep1(input logic [31:0] cap, input logic [31:0] after);
    i_in = cap;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    i_in = after;
    busy_pat = '0;
    sv_pat   = '0;
    sp_cap   = 'x;
    for (int c = 0; c < 6; c++) begin
      busy_pat[c] = busy;
      sv_pat[c]   = spike_valid;
      if (spike_valid) sp_cap = spikes;
      if (c < 5) @(negedge clk);
    end
  endtask

  // One sweep on the saturation instance; leaves the bench in the idle cycle after DONE.
  task automatic sweep2();
    tick2 = 1'b1;
    @(negedge clk);
    tick2 = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Channel 1 driven at 127 from v = 0: hand-computed trajectory, fires on sweep 11.
  task automatic fire_run(input string tag);
    int exp_v[11];
    exp_v = '{127, 247, 359, 464, 562, 654, 741, 822, 898, 969, 0};
    sel = 2'd1;
    for (int k = 0; k < 11; k++) begin
      sweep1(pack4(0, 127, 0, 0), pack4(0, 127, 0, 0));
      chk($sformatf("%s_v1_s%0d", tag, k + 1), v_mon, exp_v[k]);
      chk($sformatf("%s_spk_s%0d", tag, k + 1), sp_cap, (k == 10) ? 2 : 0);
    end
  endtask

  initial begin
    int exp_r[4];
    logic sv_seen;
    int n_fire;
    logic signed [15:0] prev_v;

    rst = 1'b1; rst2 = 1'b1; tick = 1'b0; tick2 = 1'b0; clr = 1'b0; clr2 = 1'b0;
    i_in = '0; i_in2 = '0; sel = '0; sel2 = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_sv", spike_valid, 0);
    chk("rst_spikes", spikes, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_vmon", v_mon, 0);
    chk("rst_vmon_sat", v_mon2, 0);
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);

    // Integration and sweep timing
    sel = 2'd0;
    sweep1(pack4(100, 0, 0, 0), pack4(100, 0, 0, 0));
    chk("int1_v0", v_mon, 100);
    chk("int1_busy_pat", busy_pat, 6'b011111);
    chk("int1_sv_pat", sv_pat, 6'b010000);
    chk("int1_spikes", sp_cap, 0);
    // back-to-back tick at t+6; input change after capture must be ignored
    sweep1(pack4(100, 0, 0, 0), pack4(-50, 0, 0, 0));
    chk("int2_v0", v_mon, 194);
    chk("int2_sv_pat", sv_pat, 6'b010000);

    // Overrun: second tick at t+2 dropped
    i_in = pack4(100, 0, 0, 0);
    tick = 1'b1; @(negedge clk);
    tick = 1'b0; @(negedge clk);
    tick = 1'b1; @(negedge clk);
    tick = 1'b0;
    repeat (6) @(negedge clk);
    chk("ovr_set", overrun, 1);
    chk("ovr_v0", v_mon, 282);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("ovr_clr", overrun, 0);
    // clear coinciding with a dropped tick: the drop wins
    tick = 1'b1; @(negedge clk);
    tick = 1'b0; @(negedge clk);
    tick = 1'b1; clr = 1'b1; @(negedge clk);
    tick = 1'b0; clr = 1'b0;
    repeat (6) @(negedge clk);
    chk("ovr_drop_wins", overrun, 1);
    chk("ovr_v0_b", v_mon, 365);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("ovr_clr_b", overrun, 0);

    // Firing on channel 1
    fire_run("fire");
    chk("fire_hold", spikes, 2);

    // Reset in cycle t+2 of a sweep
    sel = 2'd0;
    i_in = pack4(0, 127, 0, 0);
    tick = 1'b1; @(negedge clk);
    tick = 1'b0; @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rmid_busy", busy, 0);
    chk("rmid_spikes", spikes, 0);
    chk("rmid_sv", spike_valid, 0);
    sv_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (spike_valid) sv_seen = 1'b1;
    end
    chk("rmid_no_sv", sv_seen, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rmid_vmon", v_mon, 0);
    chk("rmid_busy_after", busy, 0);

    // Fire again from reset, then look at the sweeps following the spike
    fire_run("refire");
`ifdef LIF_REFRACT_EN
    exp_r = '{0, 0, 0, 127};
`else
    exp_r = '{127, 247, 359, 464};
`endif
    for (int k = 0; k < 4; k++) begin
      sweep1(pack4(0, 127, 0, 0), pack4(0, 127, 0, 0));
      chk($sformatf("post_v1_s%0d", k + 12), v_mon, exp_r[k]);
      chk($sformatf("post_spk_s%0d", k + 12), sp_cap, 0);
    end

    // Saturation: strong negative drive pins at the floor
    i_in2 = pack4(-128, 0, 0, 0);
    sweep2();
    chk("sat_first", v_mon2, -128);
    repeat (299) sweep2();
    chk("sat_floor", v_mon2, -32768);
    sweep2();
    chk("sat_floor_hold", v_mon2, -32768);

    // Positive drive climbs to the ceiling and fires on the clamped value
    i_in2 = pack4(127, 0, 0, 0);
    n_fire = -1;
    prev_v = v_mon2;
    for (int n = 1; n <= 600; n++) begin
      sweep2();
      if (spikes2[0]) begin
        n_fire = n;
        break;
      end
      prev_v = v_mon2;
    end
    chk("sat_fire_sweep", n_fire, 515);
    chk("sat_pre_fire_v", prev_v, 32766);
    chk("sat_post_fire_v", v_mon2, 0);
    chk("sat_other_bits", spikes2[3:1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
